// File: rtl/saph_fpu_addmul.sv
// Pipelined binary32 add/sub/mul unit: request register, three arithmetic stages, result register.
// Round-toward-zero, denormal inputs flushed to zero, no denormal outputs.
module saph_fpu_addmul #(
    parameter int latency = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_trig,
    output logic        d_ready,
    input  logic [31:0] d_lhs,
    input  logic [31:0] d_rhs,
    input  logic [1:0]  d_mode,
    output logic        q_trig,
    output logic [31:0] q_res,
    output logic [3:0]  has_modes
);

    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

    generate
        if (latency != 3) begin : g_bad_latency
            $error("saph_fpu_addmul: only latency 3 is implemented");
        end
    endgenerate

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end
        end
        return n;
    endfunction

    logic              ready_r, in_v_r;
    logic [31:0]       lhs_r, rhs_r;
    logic [1:0]        mode_r;

    logic              a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic              sa_s, sb_eff_s, swap_s;
    logic [23:0]       man_a_s, man_b_s;
    logic              s1_mul_s, s1_sign_s, s1_sub_s, s1_zsign_s, s1_spec_s;
    logic signed [9:0] s1_exp_s;
    logic [7:0]        s1_diff_s;
    logic [23:0]       s1_mh_s, s1_ml_s;
    logic [31:0]       s1_spec_val_s;

    logic              s1_v_r, s1_mul_r, s1_sign_r, s1_sub_r, s1_zsign_r, s1_spec_r;
    logic signed [9:0] s1_exp_r;
    logic [7:0]        s1_diff_r;
    logic [23:0]       s1_mh_r, s1_ml_r;
    logic [31:0]       s1_spec_val_r;

    logic [4:0]        sh_s;
    logic [26:0]       aligned_s;
    logic [27:0]       sum_s;
    logic [47:0]       prod_s;

    logic              s2_v_r, s2_mul_r, s2_sign_r, s2_zsign_r, s2_spec_r;
    logic signed [9:0] s2_exp_r;
    logic [27:0]       s2_sum_r;
    logic [24:0]       s2_prod_r;
    logic [31:0]       s2_spec_val_r;

    logic [4:0]        lz_s;
    logic [26:0]       norm_s;
    logic signed [9:0] exp_s;
    logic [22:0]       mant_s;
    logic              zero_s;
    logic [31:0]       res_s;

    logic              q_trig_r;
    logic [31:0]       q_res_r;
    logic              unused_s;

    assign unused_s  = ^{prod_s[22:0], norm_s[26], norm_s[2:0]};
    assign d_ready   = ready_r;
    assign q_trig    = q_trig_r;
    assign q_res     = q_res_r;
    assign has_modes = 4'b0111;

    // Request capture; ready rises on the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_r <= 1'b0;
            in_v_r  <= 1'b0;
            lhs_r   <= 32'd0;
            rhs_r   <= 32'd0;
            mode_r  <= 2'd0;
        end else begin
            ready_r <= 1'b1;
            in_v_r  <= d_trig & ready_r;
            if (d_trig & ready_r) begin
                lhs_r  <= d_lhs;
                rhs_r  <= d_rhs;
                mode_r <= d_mode;
            end
        end
    end

    // S1: unpack, flush denormals, order magnitudes, classify specials
    always_comb begin
        a_zero_s = (lhs_r[30:23] == 8'd0);
        b_zero_s = (rhs_r[30:23] == 8'd0);
        a_inf_s  = (lhs_r[30:23] == 8'hFF) && (lhs_r[22:0] == 23'd0);
        b_inf_s  = (rhs_r[30:23] == 8'hFF) && (rhs_r[22:0] == 23'd0);
        a_nan_s  = (lhs_r[30:23] == 8'hFF) && (lhs_r[22:0] != 23'd0);
        b_nan_s  = (rhs_r[30:23] == 8'hFF) && (rhs_r[22:0] != 23'd0);
        man_a_s  = a_zero_s ? 24'd0 : {1'b1, lhs_r[22:0]};
        man_b_s  = b_zero_s ? 24'd0 : {1'b1, rhs_r[22:0]};
        sa_s     = lhs_r[31];
        sb_eff_s = rhs_r[31] ^ (mode_r == 2'd1);
        swap_s   = (b_zero_s ? 31'd0 : rhs_r[30:0]) > (a_zero_s ? 31'd0 : lhs_r[30:0]);
        s1_mul_s = (mode_r == 2'd2);
        if (s1_mul_s) begin
            s1_sign_s  = lhs_r[31] ^ rhs_r[31];
            s1_zsign_s = lhs_r[31] ^ rhs_r[31];
            s1_sub_s   = 1'b0;
            s1_exp_s   = $signed({2'b00, lhs_r[30:23]}) + $signed({2'b00, rhs_r[30:23]}) - 10'sd127;
            s1_diff_s  = 8'd0;
            s1_mh_s    = man_a_s;
            s1_ml_s    = man_b_s;
        end else if (swap_s) begin
            s1_sign_s  = sb_eff_s;
            s1_zsign_s = sa_s & sb_eff_s;
            s1_sub_s   = sa_s ^ sb_eff_s;
            s1_exp_s   = $signed({2'b00, rhs_r[30:23]});
            s1_diff_s  = rhs_r[30:23] - lhs_r[30:23];
            s1_mh_s    = man_b_s;
            s1_ml_s    = man_a_s;
        end else begin
            s1_sign_s  = sa_s;
            s1_zsign_s = sa_s & sb_eff_s;
            s1_sub_s   = sa_s ^ sb_eff_s;
            s1_exp_s   = $signed({2'b00, lhs_r[30:23]});
            s1_diff_s  = lhs_r[30:23] - rhs_r[30:23];
            s1_mh_s    = man_a_s;
            s1_ml_s    = man_b_s;
        end
        // Specials resolved here and carried alongside the datapath
        s1_spec_s     = 1'b1;
        s1_spec_val_s = QNAN_C;
        if (a_nan_s || b_nan_s || (mode_r == 2'd3)) begin
            s1_spec_val_s = QNAN_C;
        end else if (s1_mul_s) begin
            if ((a_zero_s && b_inf_s) || (a_inf_s && b_zero_s)) begin
                s1_spec_val_s = QNAN_C;
            end else if (a_inf_s || b_inf_s) begin
                s1_spec_val_s = {lhs_r[31] ^ rhs_r[31], 8'hFF, 23'd0};
            end else begin
                s1_spec_s = 1'b0;
            end
        end else begin
            if (a_inf_s && b_inf_s && (sa_s != sb_eff_s)) begin
                s1_spec_val_s = QNAN_C;
            end else if (a_inf_s) begin
                s1_spec_val_s = {sa_s, 8'hFF, 23'd0};
            end else if (b_inf_s) begin
                s1_spec_val_s = {sb_eff_s, 8'hFF, 23'd0};
            end else begin
                s1_spec_s = 1'b0;
            end
        end
    end

    // S1 pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_r        <= 1'b0;
            s1_mul_r      <= 1'b0;
            s1_sign_r     <= 1'b0;
            s1_sub_r      <= 1'b0;
            s1_zsign_r    <= 1'b0;
            s1_spec_r     <= 1'b0;
            s1_exp_r      <= 10'sd0;
            s1_diff_r     <= 8'd0;
            s1_mh_r       <= 24'd0;
            s1_ml_r       <= 24'd0;
            s1_spec_val_r <= 32'd0;
        end else begin
            s1_v_r        <= in_v_r;
            s1_mul_r      <= s1_mul_s;
            s1_sign_r     <= s1_sign_s;
            s1_sub_r      <= s1_sub_s;
            s1_zsign_r    <= s1_zsign_s;
            s1_spec_r     <= s1_spec_s;
            s1_exp_r      <= s1_exp_s;
            s1_diff_r     <= s1_diff_s;
            s1_mh_r       <= s1_mh_s;
            s1_ml_r       <= s1_ml_s;
            s1_spec_val_r <= s1_spec_val_s;
        end
    end

    // S2: align with three truncated guard bits and add/subtract, or multiply
    always_comb begin
        sh_s      = (s1_diff_r > 8'd26) ? 5'd26 : s1_diff_r[4:0];
        aligned_s = {s1_ml_r, 3'b000} >> sh_s;
        if (s1_sub_r) begin
            sum_s = {1'b0, s1_mh_r, 3'b000} - {1'b0, aligned_s};
        end else begin
            sum_s = {1'b0, s1_mh_r, 3'b000} + {1'b0, aligned_s};
        end
        prod_s = {24'd0, s1_mh_r} * {24'd0, s1_ml_r};
    end

    // S2 pipeline register; only the product bits that can reach the mantissa are kept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v_r        <= 1'b0;
            s2_mul_r      <= 1'b0;
            s2_sign_r     <= 1'b0;
            s2_zsign_r    <= 1'b0;
            s2_spec_r     <= 1'b0;
            s2_exp_r      <= 10'sd0;
            s2_sum_r      <= 28'd0;
            s2_prod_r     <= 25'd0;
            s2_spec_val_r <= 32'd0;
        end else begin
            s2_v_r        <= s1_v_r;
            s2_mul_r      <= s1_mul_r;
            s2_sign_r     <= s1_sign_r;
            s2_zsign_r    <= s1_zsign_r;
            s2_spec_r     <= s1_spec_r;
            s2_exp_r      <= s1_exp_r;
            s2_sum_r      <= sum_s;
            s2_prod_r     <= prod_s[47:23];
            s2_spec_val_r <= s1_spec_val_r;
        end
    end

    // S3: normalise, truncate, range-check exponent and pack
    always_comb begin
        lz_s   = lzc27(s2_sum_r[26:0]);
        norm_s = s2_sum_r[26:0] << lz_s;
        if (s2_mul_r) begin
            zero_s = (s2_prod_r == 25'd0);
            if (s2_prod_r[24]) begin
                mant_s = s2_prod_r[23:1];
                exp_s  = s2_exp_r + 10'sd1;
            end else begin
                mant_s = s2_prod_r[22:0];
                exp_s  = s2_exp_r;
            end
        end else begin
            zero_s = (s2_sum_r == 28'd0);
            if (s2_sum_r[27]) begin
                mant_s = s2_sum_r[26:4];
                exp_s  = s2_exp_r + 10'sd1;
            end else begin
                mant_s = norm_s[25:3];
                exp_s  = s2_exp_r - $signed({5'd0, lz_s});
            end
        end
        if (s2_spec_r) begin
            res_s = s2_spec_val_r;
        end else if (zero_s) begin
            res_s = {s2_zsign_r, 31'd0};
        end else if (exp_s > 10'sd254) begin
            res_s = {s2_sign_r, 31'h7F7F_FFFF};
        end else if (exp_s < 10'sd1) begin
            res_s = {s2_sign_r, 31'd0};
        end else begin
            res_s = {s2_sign_r, exp_s[7:0], mant_s};
        end
    end

    // Result register; q_res only moves on a valid result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_trig_r <= 1'b0;
            q_res_r  <= 32'd0;
        end else begin
            q_trig_r <= s2_v_r;
            if (s2_v_r) begin
                q_res_r <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_saph_fpu_addmul.sv
// Self-checking bench for saph_fpu_addmul: directed vectors with fixed expectations plus
// a queue scoreboard fed by a behavioural RTZ/FTZ model for back-to-back and random traffic.
module tb_saph_fpu_addmul;

    logic        clk;
    logic        rst;
    logic        d_trig;
    logic        d_ready;
    logic [31:0] d_lhs;
    logic [31:0] d_rhs;
    logic [1:0]  d_mode;
    logic        q_trig;
    logic [31:0] q_res;
    logic [3:0]  has_modes;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];

    saph_fpu_addmul #(.latency(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_trig    (d_trig),
        .d_ready   (d_ready),
        .d_lhs     (d_lhs),
        .d_rhs     (d_rhs),
        .d_mode    (d_mode),
        .q_trig    (q_trig),
        .q_res     (q_res),
        .has_modes (has_modes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack(input logic sr, input int e, input longint sig);
        logic [7:0] e8;
        if (e > 254) return {sr, 31'h7F7F_FFFF};
        if (e < 1) return {sr, 31'h0};
        e8 = e[7:0];
        return {sr, e8, sig[22:0]};
    endfunction

    // Reference: operands as integers scaled by 8 (three guard bits), shift capped at 26
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        int     ea, eb, eh, el, e, sh;
        longint ma, mb, mh, ml, s;
        logic   sa, sb, sr, a0, b0, ai, bi, an, bn;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = b[31];
        a0 = (ea == 0);
        b0 = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        ma = a0 ? 64'sd0 : (longint'(a[22:0]) + 64'sd8388608);
        mb = b0 ? 64'sd0 : (longint'(b[22:0]) + 64'sd8388608);
        if (an || bn || m == 2'd3) return 32'h7FC0_0000;
        if (m == 2'd2) begin
            sr = sa ^ sb;
            if ((a0 && bi) || (ai && b0)) return 32'h7FC0_0000;
            if (ai || bi) return {sr, 8'hFF, 23'd0};
            if (a0 || b0) return {sr, 31'h0};
            s = ma * mb;
            if (s[47]) return pack(sr, ea + eb - 126, s >> 24);
            return pack(sr, ea + eb - 127, s >> 23);
        end
        if (m == 2'd1) sb = ~sb;
        if (ai && bi && (sa != sb)) return 32'h7FC0_0000;
        if (ai) return {sa, 8'hFF, 23'd0};
        if (bi) return {sb, 8'hFF, 23'd0};
        if ((eb > ea) || ((eb == ea) && (mb > ma))) begin
            eh = eb; mh = mb; el = ea; ml = ma; sr = sb;
        end else begin
            eh = ea; mh = ma; el = eb; ml = mb; sr = sa;
        end
        sh = eh - el;
        if (sh > 26) sh = 26;
        if (sa == sb) s = mh * 8 + ((ml * 8) >> sh);
        else s = mh * 8 - ((ml * 8) >> sh);
        if (s == 0) return {sa & sb, 31'h0};
        e = eh;
        if (s >= 64'sd134217728) begin
            s = s >> 1;
            e = e + 1;
        end else begin
            while (s < 64'sd67108864) begin
                s = s << 1;
                e = e - 1;
            end
        end
        return pack(sr, e, s >> 3);
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic [31:0] want, input bit push);
        d_lhs  = a;
        d_rhs  = b;
        d_mode = m;
        d_trig = 1'b1;
        if (push) begin
            exp_q.push_back(want);
            cyc_q.push_back(cyc + 1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        d_trig = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        d_trig = 1'b0;
        while ((exp_q.size() != 0) && (budget < 20)) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic run_monitor();
        logic [31:0] want;
        int          issued;
        forever begin
            @(negedge clk);
            if (q_trig === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got %08h want no result", q_res);
                end else begin
                    want   = exp_q.pop_front();
                    issued = cyc_q.pop_front();
                    if (q_res !== want) begin
                        bad++;
                        $display("FAIL result: got %08h want %08h", q_res, want);
                    end
                    total++;
                    if (cyc != issued + 3) begin
                        bad++;
                        $display("FAIL latency: got cycle %0d want %0d", cyc, issued + 3);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        d_trig = 1'b0;
        d_lhs  = 32'd0;
        d_rhs  = 32'd0;
        d_mode = 2'd0;
        repeat (3) @(negedge clk);
        total++;
        if (d_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", d_ready); end
        total++;
        if (q_trig !== 1'b0) begin bad++; $display("FAIL reset_q_trig: got %0b want 0", q_trig); end
        total++;
        if (q_res !== 32'd0) begin bad++; $display("FAIL reset_q_res: got %08h want 0", q_res); end
        // release together with a request: that request must be ignored
        rst    = 1'b1;
        d_trig = 1'b1;
        d_lhs  = 32'h3F80_0000;
        d_rhs  = 32'h4000_0000;
        @(negedge clk);
        d_trig = 1'b0;
        total++;
        if (d_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %0b want 1", d_ready); end
        repeat (5) begin
            @(negedge clk);
            total++;
            if (q_trig !== 1'b0) begin bad++; $display("FAIL release_coincident: got %0b want 0", q_trig); end
        end
    endtask

    task automatic test_add();
        send(32'h3F80_0000, 32'h4000_0000, 2'd0, 32'h4040_0000, 1'b1);
        idle(1);
        send(32'h3F80_0000, 32'h3380_0000, 2'd0, 32'h3F80_0000, 1'b1);
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 2'd0, 32'h7F7F_FFFF, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 2'd0, 32'h8000_0000, 1'b1);
        send(32'h0000_0000, 32'h8000_0000, 2'd0, 32'h0000_0000, 1'b1);
        send(32'hFF80_0000, 32'h3F80_0000, 2'd0, 32'hFF80_0000, 1'b1);
        wait_drain();
    endtask

    task automatic test_sub_nan();
        send(32'h3F80_0000, 32'h3F80_0000, 2'd1, 32'h0000_0000, 1'b1);
        send(32'h7F80_0000, 32'h7F80_0000, 2'd1, 32'h7FC0_0000, 1'b1);
        send(32'h3F80_0000, 32'h4000_0000, 2'd3, 32'h7FC0_0000, 1'b1);
        send(32'h8000_0000, 32'h0000_0000, 2'd1, 32'h8000_0000, 1'b1);
        send(32'h3F80_0000, 32'h0080_0000, 2'd1, 32'h3F7F_FFFF, 1'b1);
        send(32'h7FC1_2345, 32'h3F80_0000, 2'd0, 32'h7FC0_0000, 1'b1);
        wait_drain();
    endtask

    task automatic test_mul();
        send(32'h3FC0_0000, 32'hC000_0000, 2'd2, 32'hC040_0000, 1'b1);
        send(32'h7F00_0000, 32'h4000_0000, 2'd2, 32'h7F7F_FFFF, 1'b1);
        send(32'h0000_0001, 32'h3F80_0000, 2'd2, 32'h0000_0000, 1'b1);
        send(32'h0000_0000, 32'h7F80_0000, 2'd2, 32'h7FC0_0000, 1'b1);
        send(32'hFF00_0000, 32'h4000_0000, 2'd2, 32'hFF7F_FFFF, 1'b1);
        send(32'h0080_0000, 32'h0080_0000, 2'd2, 32'h0000_0000, 1'b1);
        send(32'h8000_0000, 32'h3F80_0000, 2'd2, 32'h8000_0000, 1'b1);
        send(32'h7F80_0000, 32'hC000_0000, 2'd2, 32'hFF80_0000, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [5];
        logic [31:0] b [5];
        logic [1:0]  m [5];
        a = '{32'h4049_0FDB, 32'h3F80_0000, 32'h4049_0FDB, 32'hC2C8_0000, 32'h3DCC_CCCD};
        b = '{32'h402D_F854, 32'h3F7F_FFFF, 32'h402D_F854, 32'h42C8_0001, 32'h4120_0000};
        m = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
        total++;
        if (d_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %0b want 1", d_ready); end
        for (int i = 0; i < 5; i++) begin
            send(a[i], b[i], m[i], model(a[i], b[i], m[i]), 1'b1);
        end
        wait_drain();
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            send(32'h3F80_0000, 32'h4000_0000, 2'd0, 32'd0, 1'b0);
        end
        d_trig = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (d_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %0b want 0", d_ready); end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            total++;
            if (q_trig !== 1'b0) begin bad++; $display("FAIL flush_q_trig: got %0b want 0", q_trig); end
        end
        total++;
        if (d_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_back: got %0b want 1", d_ready); end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 11))
            0:       return 32'h0000_0000 | ($urandom & 32'h8000_0000);
            1:       return $urandom & 32'h807F_FFFF;
            2:       return 32'h7F80_0000 | ($urandom & 32'h8000_0000);
            3:       return 32'h7F80_0001 | ($urandom & 32'h807F_FFFF);
            4:       return 32'h7F00_0000 | ($urandom & 32'h807F_FFFF);
            5:       return 32'h0080_0000 | ($urandom & 32'h807F_FFFF);
            6, 7, 8: return 32'h3F00_0000 | ($urandom & 32'h80FF_FFFF);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  m;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                a = rnd_op();
                if ($urandom_range(0, 3) == 0) begin
                    b = {1'($urandom), a[30:0] ^ ($urandom & 32'h0000_00FF)};
                end else begin
                    b = rnd_op();
                end
                m = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                send(a, b, m, model(a, b, m), 1'b1);
            end
        end
        wait_drain();
    endtask

    task automatic test_static();
        total++;
        if (has_modes !== 4'b0111) begin bad++; $display("FAIL has_modes: got %04b want 0111", has_modes); end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_static();
        test_add();
        test_sub_nan();
        test_mul();
        test_back_to_back();
        test_reset_flush();
        test_static();
        test_random();
        test_static();
        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
